rvsteel_spi_sequencer: RTL and testbench

Bus-mastering front end placed directly upstream of the SPI controller. It buffers TX bytes from the CPU in a FIFO and drives the SPI controller's IO interface to select a chip, send each byte, poll busy and collect the received byte. Received bytes go into an RX FIFO. The CPU can stream multi-byte transactions without polling the SPI controller byte by byte.

---
 rtl/rvsteel_spi_sequencer_pkg.sv | 44 ++++
 rtl/rvsteel_spi_seq_fifo.sv | 50 +++++
 rtl/rvsteel_spi_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_rvsteel_spi_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvsteel_spi_sequencer_pkg.sv
// rtl/rvsteel_spi_sequencer_pkg.sv - shared constants, register map and state encoding for the SPI sequencer
package rvsteel_spi_sequencer_pkg;

  // Downstream SPI controller register offsets
  localparam logic [7:0] SPI_CPOL = 8'h00;
  localparam logic [7:0] SPI_CPHA = 8'h04;
  localparam logic [7:0] SPI_CS   = 8'h08;
  localparam logic [7:0] SPI_DIV  = 8'h0c;
  localparam logic [7:0] SPI_TX   = 8'h10;
  localparam logic [7:0] SPI_RX   = 8'h14;
  localparam logic [7:0] SPI_BUSY = 8'h18;

  localparam logic [7:0] CS_NONE = 8'hff;

  // CPU-facing register index, rw_address[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int ST_BUSY   = 16;
  localparam int ST_TX_OVF = 17;
  localparam int ST_RX_OVF = 18;
  localparam int ST_DONE   = 19;

  localparam logic [31:0] UNMAPPED = 32'hdeadbeef;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_LOAD,
    S_SETTLE,
    S_POLL,
    S_RXRD,
    S_REL
  } seq_state_t;

  typedef struct packed {
    logic       irq_en;
    logic [7:0] cs_index;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/rvsteel_spi_seq_fifo.sv
// rtl/rvsteel_spi_seq_fifo.sv - synchronous 8-bit FIFO with occupancy count
module rvsteel_spi_seq_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign pop_data = mem[rptr];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/rvsteel_spi_sequencer.sv
// rtl/rvsteel_spi_sequencer.sv - CPU-facing FIFO front end that drives the SPI controller register interface
module rvsteel_spi_sequencer
  import rvsteel_spi_sequencer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS     = 32'h80004000,
  parameter logic [31:0] SPI_BASE_ADDRESS = 32'h80003000,
  parameter int          FIFO_DEPTH       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic [31:0] m_rw_address,
  input  logic [31:0] m_read_data,
  output logic        m_read_request,
  input  logic        m_read_response,
  output logic [31:0] m_write_data,
  output logic [3:0]  m_write_strobe,
  output logic        m_write_request,
  input  logic        m_write_response,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic          tx_drop;
  logic          rx_drop;
  logic [7:0]    tx_head;
  logic [7:0]    rx_head;
  logic          tx_push;
  logic          tx_pop;
  logic          rx_push;
  logic          rx_pop;

  ctrl_t         ctrl;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          done;
  logic [31:0]   status;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          wr_en;
  logic          rd_en;
  logic          status_clr;

  seq_state_t    state;
  seq_state_t    next_state;
  logic          pending;
  logic [1:0]    settle_cnt;
  logic          issue_wr;
  logic          issue_rd;
  logic [7:0]    issue_offset;
  logic [31:0]   issue_data;
  logic          set_done;

  assign sel        = rw_address[31:4] == BASE_ADDRESS[31:4];
  assign reg_idx    = rw_address[3:2];
  assign wr_en      = write_request && (|write_strobe) && sel;
  assign rd_en      = read_request && sel;
  assign tx_push    = wr_en && (reg_idx == REG_TXDATA);
  assign rx_pop     = rd_en && (reg_idx == REG_RXDATA);
  assign status_clr = wr_en && (reg_idx == REG_STATUS);

  rvsteel_spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (write_data[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .drop      (tx_drop)
  );

  rvsteel_spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (m_read_data[7:0]),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .drop      (rx_drop)
  );

  always_comb begin
    status            = '0;
    status[7:0]       = 8'(tx_count);
    status[15:8]      = 8'(rx_count);
    status[ST_BUSY]   = state != S_IDLE;
    status[ST_TX_OVF] = tx_ovf;
    status[ST_RX_OVF] = rx_ovf;
    status[ST_DONE]   = done;
  end

  assign irq = ctrl.irq_en && (done || tx_ovf || rx_ovf);

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data      <= UNMAPPED;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      ctrl           <= '0;
      tx_ovf         <= 1'b0;
      rx_ovf         <= 1'b0;
      done           <= 1'b0;
    end else begin
      read_response  <= read_request;
      write_response <= write_request;
      if (read_request) begin
        if (!sel) begin
          read_data <= UNMAPPED;
        end else begin
          case (reg_idx)
            REG_RXDATA: read_data <= rx_empty ? 32'h0 : {1'b1, 23'b0, rx_head};
            REG_CTRL:   read_data <= {15'b0, ctrl.irq_en, ctrl.cs_index, 7'b0, ctrl.en};
            REG_STATUS: read_data <= status;
            default:    read_data <= UNMAPPED;
          endcase
        end
      end
      if (wr_en && (reg_idx == REG_CTRL)) begin
        ctrl.en       <= write_data[0];
        ctrl.cs_index <= write_data[15:8];
        ctrl.irq_en   <= write_data[16];
      end
      // A new event in the same cycle as a write-1-to-clear keeps the flag set
      tx_ovf <= (tx_ovf && !(status_clr && write_data[ST_TX_OVF])) || tx_drop;
      rx_ovf <= (rx_ovf && !(status_clr && write_data[ST_RX_OVF])) || rx_drop;
      done   <= (done   && !(status_clr && write_data[ST_DONE]))   || set_done;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      pending         <= 1'b0;
      settle_cnt      <= '0;
      m_rw_address    <= '0;
      m_write_data    <= '0;
      m_write_strobe  <= '0;
      m_read_request  <= 1'b0;
      m_write_request <= 1'b0;
    end else begin
      state           <= next_state;
      m_write_request <= issue_wr;
      m_read_request  <= issue_rd;
      settle_cnt      <= (state == S_SETTLE) ? settle_cnt + 1'b1 : 2'd0;
      if (issue_wr || issue_rd) begin
        pending        <= 1'b1;
        m_rw_address   <= SPI_BASE_ADDRESS + {24'b0, issue_offset};
        m_write_data   <= issue_data;
        m_write_strobe <= issue_wr ? 4'hf : 4'h0;
      end else if (m_write_response || m_read_response) begin
        pending <= 1'b0;
      end
    end
  end

  // Each master access: issue while !pending, then advance on the matching response
  always_comb begin
    next_state   = state;
    issue_wr     = 1'b0;
    issue_rd     = 1'b0;
    issue_offset = SPI_CS;
    issue_data   = '0;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    set_done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ctrl.en && !tx_empty) next_state = S_SEL;
      end
      S_SEL: begin
        if (!pending) begin
          issue_wr   = 1'b1;
          issue_data = {24'b0, ctrl.cs_index};
        end else if (m_write_response) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!pending) begin
          if (!ctrl.en || tx_empty) begin
            next_state = S_REL;
          end else if (!rx_full) begin
            issue_wr     = 1'b1;
            issue_offset = SPI_TX;
            issue_data   = {24'b0, tx_head};
            tx_pop       = 1'b1;
          end
        end else if (m_write_response) begin
          next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == 2'd2) next_state = S_POLL;
      end
      S_POLL: begin
        if (!pending) begin
          issue_rd     = 1'b1;
          issue_offset = SPI_BUSY;
        end else if (m_read_response && !m_read_data[0]) begin
          next_state = S_RXRD;
        end
      end
      S_RXRD: begin
        if (!pending) begin
          issue_rd     = 1'b1;
          issue_offset = SPI_RX;
        end else if (m_read_response) begin
          rx_push    = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_REL: begin
        if (!pending) begin
          issue_wr   = 1'b1;
          issue_data = {24'b0, CS_NONE};
        end else if (m_write_response) begin
          set_done   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  logic unused;
  assign unused = &{1'b0, rw_address[1:0], write_data[31:20], m_read_data[31:8], tx_full,
                    SPI_CPOL, SPI_CPHA, SPI_DIV};

endmodule

// File: tb/tb_rvsteel_spi_sequencer.sv
// tb/tb_rvsteel_spi_sequencer.sv - directed self-checking bench with a behavioural SPI controller model
module tb_rvsteel_spi_sequencer;

  localparam logic [31:0] BASE   = 32'h80004000;
  localparam logic [31:0] SPI    = 32'h80003000;
  localparam logic [31:0] A_TX   = BASE;
  localparam logic [31:0] A_RX   = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rw_address = '0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic [31:0] m_rw_address;
  logic [31:0] m_read_data = '0;
  logic        m_read_request;
  logic        m_read_response = 1'b0;
  logic [31:0] m_write_data;
  logic [3:0]  m_write_strobe;
  logic        m_write_request;
  logic        m_write_response = 1'b0;
  logic        irq;

  always #5 clock = ~clock;

  rvsteel_spi_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .rw_address       (rw_address),
    .read_data        (read_data),
    .read_request     (read_request),
    .read_response    (read_response),
    .write_data       (write_data),
    .write_strobe     (write_strobe),
    .write_request    (write_request),
    .write_response   (write_response),
    .m_rw_address     (m_rw_address),
    .m_read_data      (m_read_data),
    .m_read_request   (m_read_request),
    .m_read_response  (m_read_response),
    .m_write_data     (m_write_data),
    .m_write_strobe   (m_write_strobe),
    .m_write_request  (m_write_request),
    .m_write_response (m_write_response),
    .irq              (irq)
  );

  // SPI controller model: one-cycle responses, busy for busy_polls reads after each TX write,
  // RX returns the last TX byte inverted.
  int          cyc = 0;
  int          busy_polls = 0;
  int          busy_left = 0;
  int          n_busy_reads = 0;
  int          n_rx_reads = 0;
  int          n_tx_writes = 0;
  int          rx_early = 0;
  int          perr = 0;
  int          last_req = -10;
  int          tx_req_cyc = 0;
  int          min_gap = 1000;
  logic        poll_after_tx = 1'b0;
  logic [7:0]  last_tx = '0;
  logic [63:0] wlog[$];

  always @(posedge clock) begin
    cyc              <= cyc + 1;
    m_write_response <= m_write_request & ~reset;
    m_read_response  <= m_read_request & ~reset;
    if (m_write_request || m_read_request) begin
      if (cyc - last_req < 2) perr++;
      last_req = cyc;
    end
    if (m_write_request) begin
      if (m_write_strobe !== 4'hf) perr++;
      wlog.push_back({m_rw_address, m_write_data});
      if (m_rw_address == SPI + 32'h10) begin
        n_tx_writes++;
        last_tx       = m_write_data[7:0];
        busy_left     = busy_polls;
        tx_req_cyc    = cyc;
        poll_after_tx = 1'b1;
      end
    end
    if (m_read_request) begin
      if (m_write_strobe !== 4'h0) perr++;
      if (m_rw_address == SPI + 32'h18) begin
        n_busy_reads++;
        if (poll_after_tx) begin
          poll_after_tx = 1'b0;
          if (cyc - tx_req_cyc < min_gap) min_gap = cyc - tx_req_cyc;
        end
        m_read_data <= {31'b0, busy_left > 0};
        if (busy_left > 0) busy_left--;
      end else if (m_rw_address == SPI + 32'h14) begin
        n_rx_reads++;
        if (busy_left > 0) rx_early++;
        m_read_data <= {24'b0, last_tx ^ 8'hff};
      end else begin
        m_read_data <= 32'h0;
      end
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    rw_address    = a;
    write_data    = d;
    write_strobe  = 4'hf;
    write_request = 1'b1;
    @(negedge clock);
    write_request = 1'b0;
    write_strobe  = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clock);
    rw_address   = a;
    read_request = 1'b1;
    @(negedge clock);
    read_request = 1'b0;
    d = read_data;
  endtask

  task automatic wait_status_bit(input int bit_i, input string tag);
    logic [31:0] s;
    int i;
    for (i = 0; i < 300; i++) begin
      cpu_read(A_STAT, s);
      if (s[bit_i]) break;
    end
    check(tag, i < 300, 1);
  endtask

  task automatic wait_tx(input int target, input string tag);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clock);
      if (n_tx_writes >= target) break;
    end
    check(tag, i < 500, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] wlog_at(input int idx);
    return (idx < wlog.size()) ? wlog[idx] : 64'h0;
  endfunction

  logic [31:0] d;
  logic [31:0] e_addr [4];
  logic [31:0] e_data [4];
  int          wbase;
  int          bbase;
  int          rbase;
  int          tbase;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst read_data", read_data, 32'hdeadbeef);
    check("rst irq", irq, 0);
    check("rst m_req", {m_read_request, m_write_request}, 0);
    check("rst m_addr", m_rw_address, 0);
    check("rst m_strobe", m_write_strobe, 0);
    reset = 1'b0;
    cpu_read(A_STAT, d);         check("rst status", d, 0);
    cpu_read(A_CTRL, d);         check("rst ctrl", d, 0);
    cpu_read(32'h80005000, d);   check("unmapped read", d, 32'hdeadbeef);
    cpu_read(A_RX, d);           check("rx empty read", d, 0);

    // Two-byte transaction, five busy polls per byte
    busy_polls = 5;
    wbase = wlog.size(); bbase = n_busy_reads; rbase = n_rx_reads;
    cpu_write(A_TX, 32'hA5);
    cpu_write(A_TX, 32'h3C);
    cpu_write(A_CTRL, 32'h0000_0201);
    wait_status_bit(19, "t1 done wait");
    e_addr[0] = SPI + 32'h08; e_data[0] = 32'h02;
    e_addr[1] = SPI + 32'h10; e_data[1] = 32'hA5;
    e_addr[2] = SPI + 32'h10; e_data[2] = 32'h3C;
    e_addr[3] = SPI + 32'h08; e_data[3] = 32'hFF;
    check("t1 write count", wlog.size() - wbase, 4);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] w;
      w = wlog_at(wbase + i);
      check($sformatf("t1 w%0d addr", i), w[63:32], e_addr[i]);
      check($sformatf("t1 w%0d data", i), w[31:0], e_data[i]);
    end
    check("t1 poll reads", n_busy_reads - bbase, 12);
    check("t1 rx reads", n_rx_reads - rbase, 2);
    check("t1 rx before idle", rx_early, 0);
    check("t1 settle gap", min_gap >= 4, 1);
    cpu_read(A_STAT, d);  check("t1 status", d, 32'h0008_0200);
    check("t1 irq masked", irq, 0);
    cpu_read(A_RX, d);    check("t1 rx0", d, 32'h8000_005A);
    cpu_read(A_RX, d);    check("t1 rx1", d, 32'h8000_00C3);
    cpu_read(A_RX, d);    check("t1 rx empty", d, 0);
    cpu_write(A_STAT, 32'h0008_0000);
    cpu_read(A_STAT, d);  check("t1 done clear", d, 0);

    // TX overflow with EN=0, IRQ_EN=1
    cpu_write(A_CTRL, 32'h0001_0000);
    check("t3 irq idle", irq, 0);
    for (int i = 0; i < 9; i++) cpu_write(A_TX, 32'h10 + i);
    cpu_read(A_STAT, d);  check("t3 status ovf", d, 32'h0002_0008);
    check("t3 irq ovf", irq, 1);
    cpu_write(A_STAT, 32'h0002_0000);
    cpu_read(A_STAT, d);  check("t3 status clr", d, 32'h0000_0008);
    check("t3 irq clr", irq, 0);

    // RX full stall: 10 bytes total, RX holds 8
    busy_polls = 0;
    tbase = n_tx_writes;
    cpu_write(A_CTRL, 32'h0000_0001);
    repeat (40) @(negedge clock);
    cpu_write(A_TX, 32'h19);
    cpu_write(A_TX, 32'h1A);
    repeat (250) @(negedge clock);
    check("t4 sent at stall", n_tx_writes - tbase, 8);
    cpu_read(A_STAT, d);  check("t4 status stall", d, 32'h0001_0802);
    cpu_read(A_RX, d);    check("t4 rx pop", d, 32'h8000_00EF);
    repeat (80) @(negedge clock);
    check("t4 sent after pop", n_tx_writes - tbase, 9);
    cpu_read(A_STAT, d);  check("t4 status after", d, 32'h0001_0801);

    // EN cleared while byte 2 of 4 is polling
    do_reset();
    busy_polls = 20;
    tbase = n_tx_writes; wbase = wlog.size();
    for (int i = 0; i < 4; i++) cpu_write(A_TX, 32'h21 + i);
    cpu_write(A_CTRL, 32'h0000_0301);
    wait_tx(tbase + 2, "t5 byte2 wait");
    repeat (8) @(negedge clock);
    cpu_write(A_CTRL, 32'h0000_0300);
    wait_status_bit(19, "t5 done wait");
    check("t5 bytes sent", n_tx_writes - tbase, 2);
    cpu_read(A_STAT, d);  check("t5 status", d, 32'h0008_0202);
    check("t5 first write", wlog_at(wbase), {SPI + 32'h08, 32'h03});
    check("t5 release addr", wlog[$][63:32], SPI + 32'h08);
    check("t5 release data", wlog[$][31:0], 32'hFF);

    // Reset while in SETTLE: no release write afterwards
    do_reset();
    busy_polls = 5;
    tbase = n_tx_writes; wbase = wlog.size();
    cpu_write(A_TX, 32'h55);
    cpu_write(A_CTRL, 32'h0000_0001);
    wait_tx(tbase + 1, "t6 tx wait");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6 m_req", {m_read_request, m_write_request}, 0);
    check("t6 read_data", read_data, 32'hdeadbeef);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("t6 no release", wlog.size() - wbase, 2);
    cpu_read(A_STAT, d);  check("t6 status", d, 0);

    check("master protocol", perr, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
